// File: rtl/credit_rr_allocator.sv
// credit_rr_allocator: round-robin packet arbiter for one output port,
// holding the port for a whole packet and gating flits on downstream credits.
module credit_rr_allocator #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] req,
   input  logic [4:0] tail,
   input  logic       credit_in,
   output logic [4:0] grant,
   output logic [4:0] xbar_sel,
   output logic       busy,
   output logic [3:0] credits,
   output logic       credit_err
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam logic [3:0] MAX = 4'(DEPTH);
   state_t r_state, w_state_nx;
   logic [2:0] r_ptr, r_owner, w_ptr_nx, w_owner_nx, w_pick, w_idx;
   logic [3:0] r_credits, w_credits_nx;
   logic r_err, w_xfer, w_ovf;
   // scan from farthest to nearest so the nearest requester after ptr wins
   always_comb begin
      w_pick = r_owner;
      w_idx = '0;
      for (int k = 5; k >= 1; k--) begin
         w_idx = 3'((int'(r_ptr) + k) % 5);
         if (req[w_idx]) w_pick = w_idx;
      end
   end
   assign busy         = r_state == BUSY;
   assign xbar_sel     = busy ? 5'b1 << r_owner : '0;
   assign grant        = (!rst && r_credits != '0) ? xbar_sel & req : '0;
   assign w_xfer       = |grant;
   assign w_ovf        = credit_in && !w_xfer && r_credits == MAX;
   assign w_credits_nx = r_credits - 4'(w_xfer) + 4'(credit_in && !w_ovf);
   assign credits      = r_credits;
   assign credit_err   = r_err;
   always_comb begin
      w_state_nx = r_state;
      w_owner_nx = r_owner;
      w_ptr_nx   = r_ptr;
      if (r_state == IDLE && |req) begin
         w_state_nx = BUSY;
         w_owner_nx = w_pick;
      end
      if (w_xfer && tail[r_owner]) begin
         w_state_nx = IDLE;
         w_ptr_nx   = r_owner;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= 3'd4;
         r_owner   <= '0;
         r_credits <= MAX;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_ptr     <= w_ptr_nx;
         r_owner   <= w_owner_nx;
         r_credits <= w_credits_nx;
         r_err     <= r_err | w_ovf;
      end
   end
endmodule

// File: tb/tb_credit_rr_allocator.sv
// tb_credit_rr_allocator: directed scenarios then random traffic, each cycle
// checked against a packet-level reference model of the allocator.
module tb_credit_rr_allocator;
   localparam int DEPTH = 4;
   logic clk = 0, rst = 1, credit_in = 0;
   logic [4:0] req = 0, tail = 0, grant, xbar_sel, g_obs;
   logic busy, credit_err;
   logic [3:0] credits;
   int n_chk = 0, n_fail = 0;
   int m_busy, m_owner, m_ptr, m_cred, m_err;
   int order[$];

   credit_rr_allocator #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .req(req), .tail(tail), .credit_in(credit_in),
      .grant(grant), .xbar_sel(xbar_sel), .busy(busy), .credits(credits),
      .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 4; m_cred = DEPTH; m_err = 0;
   endtask

   // one clock: drive, check outputs against the model, then advance the model
   task automatic cycle(input logic r, input logic [4:0] rq, input logic [4:0] tl, input logic ci);
      logic [4:0] eg, ex;
      bit found;
      @(negedge clk);
      rst = r; req = rq; tail = tl; credit_in = ci;
      #1;
      ex = m_busy ? 5'(1 << m_owner) : 5'd0;
      eg = (!r && m_busy && rq[m_owner] && m_cred > 0) ? ex : 5'd0;
      chk("grant", 8'(grant), 8'(eg));
      chk("xbar_sel", 8'(xbar_sel), 8'(ex));
      chk("busy", 8'(busy), 8'(m_busy));
      chk("credits", 8'(credits), 8'(m_cred));
      chk("credit_err", 8'(credit_err), 8'(m_err));
      g_obs = grant;
      if (r) model_reset();
      else begin
         if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= 5; k++)
               if (!found && rq[(m_ptr + k) % 5]) begin
                  found = 1; m_owner = (m_ptr + k) % 5; m_busy = 1;
               end
         end else if (eg != 0) begin
            m_cred--;
            if (tl[m_owner]) begin m_busy = 0; m_ptr = m_owner; end
         end
         if (ci) begin
            if (eg == 0 && m_cred == DEPTH) m_err = 1;
            else m_cred++;
         end
      end
   endtask

   task automatic do_reset();
      cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 0);
   endtask

   initial begin
      // reset from power-up: outputs are unknown until the first edge
      #1 chk("rst_grant_comb", 8'(grant), 8'd0);
      repeat (2) @(posedge clk);
      model_reset();
      cycle(0, 0, 0, 0);
      chk("rst_credits", 8'(credits), 8'd4);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_xbar", 8'(xbar_sel), 8'd0);
      // single 3-flit packet from N
      cycle(0, 5'b00010, 0, 0);
      chk("sp_arb_nogrant", 8'(g_obs), 8'd0);
      cycle(0, 5'b00010, 0, 0);
      chk("sp_g1", 8'(g_obs), 8'b00010);
      cycle(0, 5'b00010, 0, 0);
      cycle(0, 5'b00010, 5'b00010, 0);
      chk("sp_g3", 8'(g_obs), 8'b00010);
      cycle(0, 0, 0, 0);
      chk("sp_idle", 8'(busy), 8'd0);
      chk("sp_credits", 8'(credits), 8'd1);
      repeat (3) cycle(0, 0, 0, 1);
      // credit stall: 6-flit packet from L with 4 credits
      cycle(0, 5'b00001, 0, 0);
      repeat (4) cycle(0, 5'b00001, 0, 0);
      cycle(0, 5'b00001, 0, 0);
      chk("cs_stall_grant", 8'(g_obs), 8'd0);
      chk("cs_stall_busy", 8'(busy), 8'd1);
      chk("cs_stall_cred", 8'(credits), 8'd0);
      cycle(0, 5'b00001, 0, 1);
      chk("cs_same_cycle", 8'(g_obs), 8'd0);
      cycle(0, 5'b00001, 0, 0);
      chk("cs_after_credit", 8'(g_obs), 8'b00001);
      cycle(0, 5'b00001, 0, 1);
      cycle(0, 5'b00001, 5'b00001, 0);
      chk("cs_last", 8'(g_obs), 8'b00001);
      repeat (4) cycle(0, 0, 0, 1);
      // fairness: every requester, single-flit packets, credit each cycle
      do_reset();
      for (int c = 0; c < 12; c++) begin
         cycle(0, 5'b11111, 5'b11111, 1);
         for (int i = 0; i < 5; i++) if (g_obs[i]) order.push_back(i);
      end
      chk("fair_count", 8'(order.size()), 8'd6);
      for (int i = 0; i < 6 && i < order.size(); i++) chk("fair_order", 8'(order[i]), 8'(i % 5));
      chk("fair_credits", 8'(credits), 8'd4);
      // credit arithmetic
      do_reset();
      cycle(0, 5'b00001, 0, 0);
      cycle(0, 5'b00001, 0, 0);
      cycle(0, 5'b00001, 0, 0);
      cycle(0, 5'b00001, 5'b00001, 1);
      cycle(0, 0, 0, 0);
      chk("ca_hold2", 8'(credits), 8'd2);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
      chk("ca_max", 8'(credits), 8'd4);
      chk("ca_err", 8'(credit_err), 8'd1);
      repeat (3) cycle(0, 0, 0, 0);
      chk("ca_err_sticky", 8'(credit_err), 8'd1);
      // mid-packet reset while E owns the port
      do_reset();
      cycle(0, 5'b00100, 0, 0);
      cycle(0, 5'b00100, 0, 0);
      cycle(0, 5'b00100, 0, 0);
      cycle(1, 5'b00100, 0, 0);
      chk("mr_grant", 8'(g_obs), 8'd0);
      cycle(0, 5'b11111, 0, 0);
      chk("mr_busy", 8'(busy), 8'd0);
      chk("mr_credits", 8'(credits), 8'd4);
      cycle(0, 5'b11111, 0, 0);
      chk("mr_from_L", 8'(xbar_sel), 8'b00001);
      // random traffic
      do_reset();
      for (int c = 0; c < 3000; c++)
         cycle($urandom_range(0, 99) == 0, 5'($urandom), 5'($urandom) & 5'($urandom),
               $urandom_range(0, 99) < 40);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
